// File: rtl/universal_full_adder_nand_overflow_bit.sv
// nand2: single 2-input NAND, the only logic primitive used by the adder.
// Latency: combinational.
// Backpressure: none.
module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// nand_full_adder_bit: one full-adder bit built from nine NAND2 gates.
// Latency: combinational.
// Backpressure: none.
module nand_full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic n1, n2, n3, x, n5, n6, n7;

    // First half adder: x = a ^ b, with n1 reused for the carry term.
    nand2 u_n1 (.a(a),  .b(b),  .y(n1));
    nand2 u_n2 (.a(a),  .b(n1), .y(n2));
    nand2 u_n3 (.a(b),  .b(n1), .y(n3));
    nand2 u_x  (.a(n2), .b(n3), .y(x));

    // Second half adder: s = x ^ c; carry combines both half-adder terms.
    nand2 u_n5 (.a(x),  .b(c),  .y(n5));
    nand2 u_n6 (.a(x),  .b(n5), .y(n6));
    nand2 u_n7 (.a(c),  .b(n5), .y(n7));
    nand2 u_s  (.a(n6), .b(n7), .y(s));
    nand2 u_co (.a(n1), .b(n5), .y(co));
endmodule

// File: rtl/universal_full_adder_nand_overflow.sv
// Ripple-carry adder from NAND2 cells with carry-out and signed overflow.
// Latency: 1 cycle when REG_OUT=1, combinational when REG_OUT=0.
// Backpressure: none; a result is produced every cycle.
module universal_full_adder_nand_overflow #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);
    localparam logic [WIDTH-1:0] SUM_RST = '0;

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;
    logic             x1, x2, x3;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand_full_adder_bit u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .c  (c[i]),
            .s  (sum_d[i]),
            .co (c[i+1])
        );
    end

    // Overflow is carry-in XOR carry-out of the MSB, again only NAND2.
    nand2 u_x1  (.a(c[WIDTH-1]), .b(c[WIDTH]), .y(x1));
    nand2 u_x2  (.a(c[WIDTH-1]), .b(x1),       .y(x2));
    nand2 u_x3  (.a(c[WIDTH]),   .b(x1),       .y(x3));
    nand2 u_ovf (.a(x2),         .b(x3),       .y(ovf_d));

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                Sum      <= SUM_RST;
                Cout     <= 1'b0;
                Overflow <= 1'b0;
            end else begin
                Sum      <= sum_d;
                Cout     <= c[WIDTH];
                Overflow <= ovf_d;
            end
        end
    end else begin : g_comb
        assign Sum      = sum_d;
        assign Cout     = c[WIDTH];
        assign Overflow = ovf_d;
    end
endmodule

// File: tb/tb_universal_full_adder_nand_overflow.sv
// Directed and random checks of the NAND adder in three configurations.
module tb_universal_full_adder_nand_overflow;
    typedef struct {
        logic a, b, cin;
        logic sum, cout, ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // WIDTH=1 registered
    logic a1 = 0, b1 = 0, c1 = 0;
    logic s1, co1, ov1;
    // WIDTH=1 combinational
    logic a0 = 0, b0 = 0, c0 = 0;
    logic s0, co0, ov0;
    // WIDTH=4 registered
    logic [3:0] a4 = '0, b4 = '0;
    logic c4 = 0;
    logic [3:0] s4;
    logic co4, ov4;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl [8];

    always #5 clk = ~clk;

    universal_full_adder_nand_overflow #(.WIDTH(1), .REG_OUT(1'b1)) dut_r1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(c1),
        .Sum(s1), .Cout(co1), .Overflow(ov1));

    universal_full_adder_nand_overflow #(.WIDTH(1), .REG_OUT(1'b0)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .Cin(c0),
        .Sum(s0), .Cout(co0), .Overflow(ov0));

    universal_full_adder_nand_overflow #(.WIDTH(4), .REG_OUT(1'b1)) dut_r4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(c4),
        .Sum(s4), .Cout(co4), .Overflow(ov4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_r1(input string name, input logic es, input logic ec, input logic eo);
        chk(name, 32'({s1, co1, ov1}), 32'({es, ec, eo}));
    endtask

    task automatic chk_r4(input string name, input logic [3:0] es, input logic ec, input logic eo);
        chk(name, 32'({s4, co4, ov4}), 32'({es, ec, eo}));
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(negedge clk);
        a4 = a; b4 = b; c4 = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] ref_sum;
        logic       ref_ovf;

        // A B Cin -> Sum Cout Overflow
        tbl[0] = '{0,0,0, 0,0,0};
        tbl[1] = '{0,0,1, 1,0,1};
        tbl[2] = '{0,1,0, 1,0,0};
        tbl[3] = '{0,1,1, 0,1,0};
        tbl[4] = '{1,0,0, 1,0,0};
        tbl[5] = '{1,0,1, 0,1,0};
        tbl[6] = '{1,1,0, 0,1,1};
        tbl[7] = '{1,1,1, 1,1,0};

        // Reset state, held across an edge with nonzero inputs
        #2;
        chk_r1("reset_r1", 1'b0, 1'b0, 1'b0);
        chk_r4("reset_r4", 4'h0, 1'b0, 1'b0);
        a1 = 1; b1 = 0; c1 = 1;
        #5; // past posedge at 5
        chk_r1("reset_hold_edge", 1'b0, 1'b0, 1'b0);

        // Release between edges: still 0 until next rising edge
        #5; // t=12
        rst_n = 1'b1;
        #1;
        chk_r1("release_before_edge", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_r1("release_first_capture", 1'b0, 1'b1, 1'b0);

        // Exhaustive WIDTH=1 registered sweep
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].cin;
            @(posedge clk); #1;
            chk_r1($sformatf("r1_vec%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf);
        end

        // Exhaustive WIDTH=1 combinational sweep, 10 ns apart
        for (int i = 0; i < 8; i++) begin
            a0 = tbl[i].a; b0 = tbl[i].b; c0 = tbl[i].cin;
            #1;
            chk($sformatf("c1_vec%0d", i), 32'({s0, co0, ov0}),
                32'({tbl[i].sum, tbl[i].cout, tbl[i].ovf}));
            #9;
        end

        // Asynchronous reset mid-stream
        @(negedge clk);
        a1 = 1; b1 = 1; c1 = 1;
        @(posedge clk); #1;
        chk_r1("pre_async_reset", 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_r1("async_reset_immediate", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk_r1($sformatf("async_reset_hold%0d", k), 1'b0, 1'b0, 1'b0);
        end
        // New inputs before release: no stale 1,1,0 may reappear
        a1 = 0; b1 = 1; c1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_r1("async_release_before_edge", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_r1("async_release_capture", 1'b1, 1'b0, 1'b0);

        // WIDTH=4 directed corners
        drive4(4'b0111, 4'b0001, 1'b0);
        chk_r4("w4_pos_overflow", 4'b1000, 1'b0, 1'b1);
        drive4(4'b1000, 4'b1000, 1'b0);
        chk_r4("w4_neg_overflow", 4'b0000, 1'b1, 1'b1);
        drive4(4'b1111, 4'b0000, 1'b1);
        chk_r4("w4_full_ripple", 4'b0000, 1'b1, 1'b0);
        drive4(4'b0101, 4'b0010, 1'b1);
        chk_r4("w4_plain", 4'b1000, 1'b0, 1'b1);

        // WIDTH=4 random against arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] ra, rb;
            logic       rc;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
            ref_ovf = (ra[3] == rb[3]) && (ref_sum[3] != ra[3]);
            drive4(ra, rb, rc);
            chk_r4($sformatf("w4_rand%0d", i), ref_sum[3:0], ref_sum[4], ref_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
